// File: rtl/board_io_pkg.sv
// board_io_pkg: shared board I/O constants for the input conditioner.
//   DB_CYCLES_SIM   debounce length used in simulation
//   DB_CYCLES_BOARD debounce length on hardware (10 ms at 125 MHz)
//   N_BTN / N_SW    number of push buttons / slide switches on the board
package board_io_pkg;
    localparam int DB_CYCLES_SIM   = 4;
    localparam int DB_CYCLES_BOARD = 1_250_000;
    localparam int N_BTN           = 4;
    localparam int N_SW            = 2;
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one channel of 2-FF sync, debounce filter and rise/fall pulses.
//   clk_i    system clock (posedge)
//   rst_ni   synchronous reset, active-low
//   raw_i    asynchronous raw pin level
//   stable_o debounced level
//   rise_o   one-cycle pulse on stable 0->1
//   fall_o   one-cycle pulse on stable 1->0
module debounce_ch
    import board_io_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_SIM
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
    logic s1_q, s2_q, stable_q, stable_d, rise_q, fall_q, differ, done;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        differ   = s2_q != stable_q;
        done     = differ && (cnt_q == LAST);
        stable_d = done ? s2_q : stable_q;
        // any return to the accepted level, or an acceptance, restarts the count
        cnt_d    = (!differ || done) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s1_q     <= raw_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= stable_d & ~stable_q;
            fall_q   <= ~stable_d & stable_q;
        end
    end
    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: N_CH-channel button/switch front end (sync, debounce, edge pulses, toggle).
//   sysclk  system clock (posedge)
//   rst_n   synchronous reset, active-low
//   raw_in  asynchronous raw pin levels
//   stable  debounced levels
//   rise    one-cycle pulses on stable 0->1
//   fall    one-cycle pulses on stable 1->0
//   toggle  press-to-toggle state; with INPUT_COND_TOGGLE_EN defined it flips on each
//           rise pulse, otherwise it is a plain copy of stable
module input_conditioner
    import board_io_pkg::*;
#(
    parameter int N_CH      = N_BTN,
    parameter int DB_CYCLES = DB_CYCLES_SIM
) (
    input  logic            sysclk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] stable,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] toggle
);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch (
            .clk_i   (sysclk),
            .rst_ni  (rst_n),
            .raw_i   (raw_in[i]),
            .stable_o(stable[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end
`ifdef INPUT_COND_TOGGLE_EN
    logic [N_CH-1:0] toggle_q;
    always_ff @(posedge sysclk) begin
        if (!rst_n) toggle_q <= '0;
        else        toggle_q <= toggle_q ^ rise;
    end
    assign toggle = toggle_q;
`else
    assign toggle = stable;
`endif
endmodule
